// File: rtl/pulse_stretcher_if.sv
// ----------------------------------------------------------------------------
// pulse_stretcher_if
// Groups the trigger input and the stretched-pulse status outputs of
// pulse_stretcher into one bundle.
//   in_pulse  : single-cycle trigger; every sampled-high cycle is one pulse
//   out_level : stretched level pulse
//   busy      : stretcher is not idle
//   pend_cnt  : queued pulses not yet replayed (PEND_W bits, saturating)
//   overflow  : one-cycle flag, a pulse was dropped on the previous edge
// The master modport belongs to the pulse source; the slave modport belongs
// to the stretcher.
// ----------------------------------------------------------------------------
interface pulse_stretcher_if #(
   parameter int PEND_W = 2
);
   logic              in_pulse;
   logic              out_level;
   logic              busy;
   logic [PEND_W-1:0] pend_cnt;
   logic              overflow;

   modport master (
      output in_pulse,
      input  out_level,
      input  busy,
      input  pend_cnt,
      input  overflow
   );

   modport slave (
      input  in_pulse,
      output out_level,
      output busy,
      output pend_cnt,
      output overflow
   );
endinterface : pulse_stretcher_if

// File: rtl/pulse_stretcher.sv
// ----------------------------------------------------------------------------
// pulse_stretcher
// Turns single-cycle trigger pulses into fixed-width level pulses. Each
// accepted pulse gives HOLD_CYCLES cycles high followed by at least
// GAP_CYCLES cycles low. Pulses arriving while a burst is running are counted
// in a saturating pending counter and replayed back to back, one burst every
// HOLD_CYCLES+GAP_CYCLES cycles.
//
// Ports:
//   clk : clock, all logic on the rising edge
//   rst : synchronous active-low reset
//   bus : pulse_stretcher_if slave modport
//         in_pulse (in), out_level, busy, pend_cnt, overflow (out)
//
// Parameters:
//   HOLD_CYCLES : high cycles per burst (>= 1)
//   GAP_CYCLES  : forced-low cycles after each high phase (>= 1)
//   PEND_W      : pending counter width; queue holds up to 2**PEND_W-1
// ----------------------------------------------------------------------------
module pulse_stretcher #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int PEND_W      = 2
) (
   input  logic             clk,
   input  logic             rst,
   pulse_stretcher_if.slave bus
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int GAP_W  = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;

   // Phase counters count down to zero; the edge that sees zero ends the phase.
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_q,  hold_d;
   logic [GAP_W-1:0]  gap_q,   gap_d;
   logic [PEND_W-1:0] pend_q,  pend_d;
   logic              ovf_q,   ovf_d;
   logic              pend_inc;
   logic              pend_dec;

   // -------------------------------------------------------------------------
   // Next-state and queue logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      state_d  = state_q;
      hold_d   = hold_q;
      gap_d    = gap_q;
      pend_d   = pend_q;
      ovf_d    = 1'b0;
      pend_inc = 1'b0;
      pend_dec = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A pulse in IDLE starts a burst directly; it is never queued.
            if (bus.in_pulse) begin
               state_d = HIGH;
               hold_d  = HOLD_LOAD;
            end
         end

         HIGH: begin
            pend_inc = bus.in_pulse;
            if (hold_q == '0) begin
               state_d = GAP;
               gap_d   = GAP_LOAD;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end

         GAP: begin
            if (gap_q != '0) begin
               gap_d    = gap_q - 1'b1;
               pend_inc = bus.in_pulse;
            end else if (pend_q != '0) begin
               // Exit edge with a queued pulse: replay it. A pulse arriving
               // on this same edge joins the queue, netting no change.
               state_d  = HIGH;
               hold_d   = HOLD_LOAD;
               pend_dec = 1'b1;
               pend_inc = bus.in_pulse;
            end else if (bus.in_pulse) begin
               // Empty queue, fresh pulse on the exit edge: go straight back
               // to HIGH without passing through IDLE or touching the queue.
               state_d = HIGH;
               hold_d  = HOLD_LOAD;
            end else begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      // Saturating queue update. A simultaneous increment and decrement
      // cancel, so a full queue never overflows on a replay edge.
      if (pend_inc && !pend_dec) begin
         if (pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + 1'b1;
         end
      end else if (pend_dec && !pend_inc) begin
         pend_d = pend_q - 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the values from before this edge, regardless of statement order.
      if (!rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
         gap_q   <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   // Outputs are decoded straight from registered state, so they are glitch
   // free and carry no combinational path from in_pulse.
   assign bus.out_level = (state_q == HIGH);
   assign bus.busy      = (state_q != IDLE);
   assign bus.pend_cnt  = pend_q;
   assign bus.overflow  = ovf_q;

endmodule : pulse_stretcher

// File: tb/tb_pulse_stretcher.sv
// ----------------------------------------------------------------------------
// tb_pulse_stretcher
// Self-checking bench for pulse_stretcher with default parameters
// (HOLD=4, GAP=2, PEND_W=2, queue max 3). A fixed vector table covers the
// saturating-queue scenario, short directed sequences cover the corner cases,
// and a long random run is compared against a countdown-based reference model.
// ----------------------------------------------------------------------------
module tb_pulse_stretcher;

   localparam int HOLD = 4;
   localparam int GAP  = 2;
   localparam int PW   = 2;
   localparam int PMAX = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;

   pulse_stretcher_if #(.PEND_W(PW)) bus ();

   pulse_stretcher #(
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP),
      .PEND_W      (PW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------------------------------------------------------- checking
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input bit o, input bit b, input int pc, input bit ov);
      check($sformatf("%s.out_level", tag), 32'(bus.out_level), 32'(o));
      check($sformatf("%s.busy",      tag), 32'(bus.busy),      32'(b));
      check($sformatf("%s.pend_cnt",  tag), 32'(bus.pend_cnt),  32'(pc));
      check($sformatf("%s.overflow",  tag), 32'(bus.overflow),  32'(ov));
   endtask

   // Drive inputs on the falling edge, let the rising edge sample them, then
   // look at the outputs 1 time unit later.
   task automatic step(input bit r, input bit p);
      @(negedge clk);
      rst          = r;
      bus.in_pulse = p;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b1, 1'b0);
   endtask

   // ---------------------------------------------------------- vector table
   typedef struct {
      bit r;
      bit p;
      bit o;
      bit b;
      int pc;
      bit ov;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit r, bit p, bit o, bit b, int pc, bit ov);
      vec_t v;
      v.r = r; v.p = p; v.o = o; v.b = b; v.pc = pc; v.ov = ov;
      vecs.push_back(v);
   endfunction

   // ------------------------------------------------------- reference model
   // The model tracks the number of cycles left in the current burst
   // (high phase plus gap) and the number of queued pulses as integers.
   int m_left;
   int m_pend;
   bit m_ovf;

   function automatic void model_step(bit r, bit p);
      m_ovf = 1'b0;
      if (!r) begin
         m_left = 0;
         m_pend = 0;
      end else if (m_left == 0) begin
         if (p) m_left = HOLD + GAP;
      end else if (m_left == 1) begin
         if (m_pend > 0) begin
            m_pend = m_pend - 1 + int'(p);
            m_left = HOLD + GAP;
         end else if (p) begin
            m_left = HOLD + GAP;
         end else begin
            m_left = 0;
         end
      end else begin
         m_left--;
         if (p) begin
            if (m_pend == PMAX) m_ovf = 1'b1;
            else                m_pend++;
         end
      end
   endfunction

   // ------------------------------------------------------------------ test
   initial begin
      bus.in_pulse = 1'b0;
      rst          = 1'b0;

      // Reset state
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      check_outs("reset", 1'b0, 1'b0, 0, 1'b0);

      // Saturation scenario: pulses on six consecutive edges e0..e5.
      add(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);   // reset row
      add(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);   // idle
      add(1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0);   // e0 burst 1 starts
      add(1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b0);   // e1
      add(1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b0);   // e2
      add(1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b0);   // e3 queue full
      add(1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1);   // e4 dropped
      add(1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1);   // e5 dropped
      add(1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0);   // e6 burst 2
      for (int i = 7; i <= 9; i++)   add(1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0);   // e10
      add(1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0);   // e11
      for (int i = 12; i <= 15; i++) add(1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0);  // burst 3
      add(1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0);   // e16
      add(1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0);   // e17
      for (int i = 18; i <= 21; i++) add(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);  // burst 4
      add(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);   // e22
      add(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);   // e23
      add(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);   // e24 idle
      add(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);   // e25

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].r, vecs[i].p);
         check_outs($sformatf("vec%0d", i), vecs[i].o, vecs[i].b, vecs[i].pc, vecs[i].ov);
      end

      // Single pulse: 4 high, 2 gap, then idle.
      step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      check_outs("single.e0", 1'b1, 1'b1, 0, 1'b0);
      idle(3);
      check_outs("single.e3", 1'b1, 1'b1, 0, 1'b0);
      idle(1);
      check_outs("single.e4", 1'b0, 1'b1, 0, 1'b0);
      idle(1);
      check_outs("single.e5", 1'b0, 1'b1, 0, 1'b0);
      idle(1);
      check_outs("single.e6", 1'b0, 1'b0, 0, 1'b0);

      // Two pulses two edges apart.
      step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      check_outs("two.e2", 1'b1, 1'b1, 1, 1'b0);
      idle(4);
      check_outs("two.e6", 1'b1, 1'b1, 0, 1'b0);
      idle(5);
      check_outs("two.e11", 1'b0, 1'b1, 0, 1'b0);
      idle(1);
      check_outs("two.e12", 1'b0, 1'b0, 0, 1'b0);

      // Full queue with a pulse on the replay edge: no change, no overflow.
      step(1'b0, 1'b0);
      repeat (4) step(1'b1, 1'b1);
      idle(2);
      check_outs("fullrep.e5", 1'b0, 1'b1, 3, 1'b0);
      step(1'b1, 1'b1);
      check_outs("fullrep.e6", 1'b1, 1'b1, 3, 1'b0);

      // Empty queue with a pulse on the gap exit edge: straight back to HIGH.
      step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      idle(5);
      check_outs("exitpulse.e5", 1'b0, 1'b1, 0, 1'b0);
      step(1'b1, 1'b1);
      check_outs("exitpulse.e6", 1'b1, 1'b1, 0, 1'b0);

      // Reset in the middle of a burst discards everything.
      step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check_outs("midrst.e1", 1'b1, 1'b1, 1, 1'b0);
      step(1'b0, 1'b1);
      check_outs("midrst.e2", 1'b0, 1'b0, 0, 1'b0);
      idle(1);
      step(1'b1, 1'b1);
      check_outs("midrst.e4", 1'b1, 1'b1, 0, 1'b0);
      idle(3);
      check_outs("midrst.e7", 1'b1, 1'b1, 0, 1'b0);
      idle(1);
      check_outs("midrst.e8", 1'b0, 1'b1, 0, 1'b0);

      // in_pulse held high for four edges: one burst plus three queued.
      step(1'b0, 1'b0);
      repeat (4) step(1'b1, 1'b1);
      check_outs("held.e3", 1'b1, 1'b1, 3, 1'b0);
      idle(14);
      check_outs("held.e17", 1'b0, 1'b1, 1, 1'b0);
      idle(1);
      check_outs("held.e18", 1'b1, 1'b1, 0, 1'b0);
      idle(5);
      check_outs("held.e23", 1'b0, 1'b1, 0, 1'b0);
      idle(1);
      check_outs("held.e24", 1'b0, 1'b0, 0, 1'b0);

      // Random traffic against the reference model.
      step(1'b0, 1'b0);
      model_step(1'b0, 1'b0);
      for (int seg = 0; seg < 8; seg++) begin
         int dens;
         dens = $urandom_range(1, 6);
         for (int c = 0; c < 400; c++) begin
            bit r;
            bit p;
            r = ($urandom_range(0, 249) != 0);
            p = ($urandom_range(0, dens) == 0);
            step(r, p);
            model_step(r, p);
            check_outs($sformatf("rand%0d_%0d", seg, c),
                       m_left > GAP, m_left > 0, m_pend, m_ovf);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pulse_stretcher
